result_slv_bank: RTL and testbench
==================================

RESULT_SLV_BANK -- requirements
Module: result_slv_bank

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI data width (32 only legal).
REQ-002 SHALL have parameter NUM_CTRL, default 4, number of software read/write control registers (1..16).
REQ-003 SHALL have parameter NUM_CH, default 4, number of hardware result channels (1..16).
REQ-004 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 7, byte-address width; must cover (NUM_CTRL+NUM_CH+2)*4 bytes.
REQ-005 SHALL have ports: S_AXI_ACLK in 1 clock; S_AXI_ARESET in 1 reset. One clock; reset is synchronous and active-high.
REQ-006 SHALL have AXI4-Lite slave ports S_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY at standard widths.
REQ-007 SHALL have res_data in NUM_CH*32 packed channel results; res_valid in NUM_CH per-channel one-cycle load strobe.
REQ-008 SHALL have ctrl_out out NUM_CTRL*32 packed control register contents.

Function
REQ-009 Register map (word index): 0..NUM_CTRL-1 control RW; NUM_CTRL..NUM_CTRL+NUM_CH-1 result RO; NUM_CTRL+NUM_CH STATUS; NUM_CTRL+NUM_CH+1 OVERRUN; address bits [1:0] ignored.
REQ-010 Write path SHALL accept AW and W independently in either order (AWREADY/WREADY each high for one cycle per beat when its latch is empty), commit write in the cycle after both are held, then assert BVALID until BREADY.
REQ-011 Write FSM states W_IDLE, W_HOLD (one of AW/W latched), W_RESP; no new AW/W accepted while in W_RESP.
REQ-012 Control writes SHALL honour WSTRB per byte; ctrl_out updates the cycle after commit.
REQ-013 Read path SHALL assert ARREADY in R_IDLE, sample register data at the AR handshake cycle, present RVALID next cycle, hold RDATA/RRESP stable until RREADY; states R_IDLE, R_DATA.
REQ-014 Read and write paths SHALL be independent and may be in flight concurrently.
REQ-015 res_valid[c] SHALL load result register c with res_data[c] and set STATUS[c]; if STATUS[c] already set, OVERRUN[c] also set.
REQ-016 STATUS and OVERRUN bits SHALL be write-1-to-clear (WSTRB honoured); set by hardware in the same cycle as a W1C SHALL win.
REQ-017 Writes to result registers SHALL be ignored with BRESP OKAY.
REQ-018 Addresses beyond the map SHALL return RDATA 0 with RRESP SLVERR; writes ignored with BRESP SLVERR.
REQ-019 Read of a result register in the same cycle as its res_valid SHALL return the pre-update value.
REQ-020 Unused upper bits of STATUS/OVERRUN SHALL read 0.

Reset
REQ-021 On S_AXI_ARESET high at a clock edge: all READY/VALID outputs 0, BRESP/RRESP 0, RDATA 0, all registers 0, ctrl_out 0, FSMs to W_IDLE/R_IDLE, irq 0.
REQ-022 Reset mid-transaction SHALL abandon the transaction with no register update and no response.

Configuration
REQ-023 With RESULT_SLV_IRQ_EN defined: output irq (1 bit) and an extra RW register IRQ_MASK at word NUM_CTRL+NUM_CH+2; irq registered = |(STATUS & IRQ_MASK), one cycle latency after status change.
REQ-024 Without RESULT_SLV_IRQ_EN: no irq port, no IRQ_MASK; that address decodes as out-of-range (SLVERR).

Structure
REQ-025 Package result_slv_pkg SHALL hold response codes (OKAY=2'b00, SLVERR=2'b10), write/read FSM state typedefs and the register-index offset functions.
REQ-026 Sub-module result_slv_axil_if SHALL implement both AXI4-Lite handshake FSMs exposing a simple wr_en/wr_idx/wr_data/wr_strb and rd_en/rd_idx/rd_data/rd_err interface; the top holds the register bank.

Verification
REQ-027 Write 0x1,0x2,0x3,0x4 to words 0..3 then read back -> RDATA 0x1..0x4, RRESP OKAY, ctrl_out matches.
REQ-028 WVALID asserted 3 cycles before AWVALID, data 0xA5A5A5A5, WSTRB 4'b0011 to word 0 preloaded 0xFFFFFFFF -> reads 0xFFFFA5A5, one BVALID.
REQ-029 Pulse res_valid[1] with 0x00000123 twice, no clear -> result word reads 0x123, STATUS=0x2, OVERRUN=0x2; write 0x2 to STATUS -> STATUS=0.
REQ-030 res_valid[0] in same cycle as W1C of STATUS[0] -> STATUS[0] remains 1.
REQ-031 Read word 0x3F (out of range) -> RDATA 0, RRESP 2'b10; write same -> BRESP 2'b10, no register changes.
REQ-032 With RESULT_SLV_IRQ_EN: IRQ_MASK=0x1, res_valid[0] -> irq high next cycle; W1C STATUS[0] -> irq low; assert reset during W_HOLD -> BVALID never asserted, all registers 0.

Source files
------------

// File: rtl/result_slv_pkg.sv
// Shared types and register-map helpers for the result_slv_bank AXI4-Lite register block.
package result_slv_pkg;

  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_HOLD = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Latched W-channel beat
  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_STRB_W-1:0] strb;
  } wr_beat_t;

  // Word indices of the register regions that follow the control registers
  function automatic int unsigned result_base(input int unsigned num_ctrl);
    return num_ctrl;
  endfunction

  function automatic int unsigned status_idx(input int unsigned num_ctrl, input int unsigned num_ch);
    return num_ctrl + num_ch;
  endfunction

  function automatic int unsigned overrun_idx(input int unsigned num_ctrl, input int unsigned num_ch);
    return num_ctrl + num_ch + 1;
  endfunction

  function automatic int unsigned irq_mask_idx(input int unsigned num_ctrl, input int unsigned num_ch);
    return num_ctrl + num_ch + 2;
  endfunction

endpackage

// File: rtl/result_slv_axil_if.sv
// AXI4-Lite slave handshake engine: turns AW/W/B and AR/R traffic into simple
// word-indexed write-commit and read-sample strobes for a register bank.
module result_slv_axil_if
  import result_slv_pkg::*;
#(
  parameter int unsigned ADDR_W = 7,
  localparam int unsigned IDX_W = ADDR_W - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [AXI_DATA_W-1:0] wdata,
  input  logic [AXI_STRB_W-1:0] wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_W-1:0]     araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [AXI_DATA_W-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  output logic                  wr_en_c,
  output logic [IDX_W-1:0]      wr_idx,
  output logic [AXI_DATA_W-1:0] wr_data,
  output logic [AXI_STRB_W-1:0] wr_strb,
  input  logic                  wr_err,
  output logic                  rd_en_c,
  output logic [IDX_W-1:0]      rd_idx_c,
  input  logic [AXI_DATA_W-1:0] rd_data,
  input  logic                  rd_err
);

  wr_state_t wr_state;
  rd_state_t rd_state;
  logic      aw_full;
  logic      w_full;
  wr_beat_t  w_beat;
  logic      unused_addr_lsb;

  assign wr_en_c         = (wr_state == W_HOLD) && aw_full && w_full;
  assign wr_data         = w_beat.data;
  assign wr_strb         = w_beat.strb;
  assign rd_en_c         = arvalid && arready;
  assign rd_idx_c        = araddr[ADDR_W-1:2];
  assign unused_addr_lsb = ^{awaddr[1:0], araddr[1:0]};

  // Write path: AW and W latch independently; commit once both are held
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= W_IDLE;
      awready  <= 1'b0;
      wready   <= 1'b0;
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      wr_idx   <= '0;
      w_beat   <= '0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
    end else begin
      unique case (wr_state)
        W_IDLE, W_HOLD: begin
          if (aw_full && w_full) begin
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            bvalid   <= 1'b1;
            bresp    <= wr_err ? RESP_SLVERR : RESP_OKAY;
            wr_state <= W_RESP;
          end else begin
            if (!aw_full) begin
              if (awvalid && awready) begin
                wr_idx  <= awaddr[ADDR_W-1:2];
                aw_full <= 1'b1;
                awready <= 1'b0;
              end else if (awvalid) begin
                awready <= 1'b1;
              end
            end
            if (!w_full) begin
              if (wvalid && wready) begin
                w_beat <= '{data: wdata, strb: wstrb};
                w_full <= 1'b1;
                wready <= 1'b0;
              end else if (wvalid) begin
                wready <= 1'b1;
              end
            end
            if (aw_full || w_full || (awvalid && awready) || (wvalid && wready)) begin
              wr_state <= W_HOLD;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid   <= 1'b0;
            wr_state <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Read path: sample bank data at the AR handshake, hold until RREADY
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= R_IDLE;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rresp    <= RESP_OKAY;
    end else begin
      unique case (rd_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            rdata    <= rd_data;
            rresp    <= rd_err ? RESP_SLVERR : RESP_OKAY;
            rvalid   <= 1'b1;
            arready  <= 1'b0;
            rd_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            rvalid   <= 1'b0;
            arready  <= 1'b1;
            rd_state <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/result_slv_bank.sv
// AXI4-Lite register bank: RW control words, RO channel results with W1C STATUS/OVERRUN.
// Define RESULT_SLV_IRQ_EN to add the IRQ_MASK register and the irq output.
module result_slv_bank
  import result_slv_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned NUM_CTRL           = 4,
  parameter int unsigned NUM_CH             = 4,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 7
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [NUM_CH*32-1:0]            res_data,
  input  logic [NUM_CH-1:0]               res_valid,
  output logic [NUM_CTRL*32-1:0]          ctrl_out
`ifdef RESULT_SLV_IRQ_EN
  ,
  output logic                            irq
`endif
);

  localparam int unsigned IDX_W       = C_S_AXI_ADDR_WIDTH - 2;
  localparam int unsigned RES_BASE    = result_base(NUM_CTRL);
  localparam int unsigned STATUS_IDX  = status_idx(NUM_CTRL, NUM_CH);
  localparam int unsigned OVERRUN_IDX = overrun_idx(NUM_CTRL, NUM_CH);
`ifdef RESULT_SLV_IRQ_EN
  localparam int unsigned IRQ_IDX     = irq_mask_idx(NUM_CTRL, NUM_CH);
  localparam int unsigned MAP_WORDS   = IRQ_IDX + 1;
`else
  localparam int unsigned MAP_WORDS   = OVERRUN_IDX + 1;
`endif

  logic                  wr_en_c;
  logic [IDX_W-1:0]      wr_idx;
  logic [AXI_DATA_W-1:0] wr_data;
  logic [AXI_STRB_W-1:0] wr_strb;
  logic                  wr_err;
  logic                  rd_en_c;
  logic [IDX_W-1:0]      rd_idx_c;
  logic [AXI_DATA_W-1:0] rd_data;
  logic                  rd_err;

  logic [NUM_CTRL-1:0][31:0] ctrl_q;
  logic [NUM_CH-1:0][31:0]   res_q;
  logic [NUM_CH-1:0]         status_q;
  logic [NUM_CH-1:0]         overrun_q;
  logic [NUM_CH-1:0]         status_clr;
  logic [NUM_CH-1:0]         overrun_clr;
  logic [31:0]               byte_mask;
  logic [31:0]               w1c_bits;
  logic                      unused_ok;

  result_slv_axil_if #(
    .ADDR_W (C_S_AXI_ADDR_WIDTH)
  ) u_axil_if (
    .clk      (S_AXI_ACLK),
    .rst      (S_AXI_ARESET),
    .awaddr   (S_AXI_AWADDR),
    .awvalid  (S_AXI_AWVALID),
    .awready  (S_AXI_AWREADY),
    .wdata    (S_AXI_WDATA),
    .wstrb    (S_AXI_WSTRB),
    .wvalid   (S_AXI_WVALID),
    .wready   (S_AXI_WREADY),
    .bresp    (S_AXI_BRESP),
    .bvalid   (S_AXI_BVALID),
    .bready   (S_AXI_BREADY),
    .araddr   (S_AXI_ARADDR),
    .arvalid  (S_AXI_ARVALID),
    .arready  (S_AXI_ARREADY),
    .rdata    (S_AXI_RDATA),
    .rresp    (S_AXI_RRESP),
    .rvalid   (S_AXI_RVALID),
    .rready   (S_AXI_RREADY),
    .wr_en_c  (wr_en_c),
    .wr_idx   (wr_idx),
    .wr_data  (wr_data),
    .wr_strb  (wr_strb),
    .wr_err   (wr_err),
    .rd_en_c  (rd_en_c),
    .rd_idx_c (rd_idx_c),
    .rd_data  (rd_data),
    .rd_err   (rd_err)
  );

  assign byte_mask   = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
  assign w1c_bits    = wr_data & byte_mask;
  assign status_clr  = (wr_en_c && (32'(wr_idx) == STATUS_IDX))  ? w1c_bits[NUM_CH-1:0] : '0;
  assign overrun_clr = (wr_en_c && (32'(wr_idx) == OVERRUN_IDX)) ? w1c_bits[NUM_CH-1:0] : '0;
  assign wr_err      = (32'(wr_idx) >= MAP_WORDS);
  assign rd_err      = (32'(rd_idx_c) >= MAP_WORDS);
  assign ctrl_out    = ctrl_q;
  assign unused_ok   = ^{S_AXI_AWPROT, S_AXI_ARPROT, rd_en_c, w1c_bits};

  // Register bank; a hardware set always beats a same-cycle W1C
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      ctrl_q    <= '0;
      res_q     <= '0;
      status_q  <= '0;
      overrun_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CTRL; i++) begin
        if (wr_en_c && (32'(wr_idx) == i)) begin
          ctrl_q[i] <= (ctrl_q[i] & ~byte_mask) | (wr_data & byte_mask);
        end
      end
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (res_valid[c]) begin
          res_q[c] <= res_data[c*32 +: 32];
        end
      end
      status_q  <= (status_q & ~status_clr) | res_valid;
      overrun_q <= (overrun_q & ~overrun_clr) | (res_valid & status_q);
    end
  end

`ifdef RESULT_SLV_IRQ_EN
  logic [NUM_CH-1:0] irq_mask_q;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      irq_mask_q <= '0;
      irq        <= 1'b0;
    end else begin
      if (wr_en_c && (32'(wr_idx) == IRQ_IDX)) begin
        irq_mask_q <= (irq_mask_q & ~byte_mask[NUM_CH-1:0]) | (wr_data[NUM_CH-1:0] & byte_mask[NUM_CH-1:0]);
      end
      irq <= |(status_q & irq_mask_q);
    end
  end
`endif

  // Read mux over current register contents (pre-update on a same-cycle load)
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_CTRL; i++) begin
      if (32'(rd_idx_c) == i) rd_data = ctrl_q[i];
    end
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (32'(rd_idx_c) == RES_BASE + c) rd_data = res_q[c];
    end
    if (32'(rd_idx_c) == STATUS_IDX)  rd_data = 32'(status_q);
    if (32'(rd_idx_c) == OVERRUN_IDX) rd_data = 32'(overrun_q);
`ifdef RESULT_SLV_IRQ_EN
    if (32'(rd_idx_c) == IRQ_IDX)     rd_data = 32'(irq_mask_q);
`endif
  end

endmodule

// File: tb/tb_result_slv_bank.sv
// Directed self-checking bench for result_slv_bank (optionally with RESULT_SLV_IRQ_EN).
module tb_result_slv_bank;

  localparam int unsigned AW = 7;

  logic         clk = 1'b0;
  logic         rst;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [127:0] res_data;
  logic [3:0]   res_valid;
  logic [127:0] ctrl_out;
`ifdef RESULT_SLV_IRQ_EN
  logic         irq;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0]  rd_val;
  logic [1:0]   resp;
  int           bcount;

  always #5 clk = ~clk;

  result_slv_bank dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .res_data      (res_data),
    .res_valid     (res_valid),
    .ctrl_out      (ctrl_out)
`ifdef RESULT_SLV_IRQ_EN
    ,
    .irq           (irq)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // W is presented first; AW follows w_lead cycles later (0 = together)
  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead, output logic [1:0] r);
    int  n = 0;
    bit  hs_aw, hs_w;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb; wvalid = 1'b1;
    if (w_lead == 0) awvalid = 1'b1;
    while ((awvalid || wvalid || n < w_lead) && n < 60) begin
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(negedge clk);
      n++;
      if (hs_aw) awvalid = 1'b0;
      if (hs_w)  wvalid = 1'b0;
      if (w_lead > 0 && n == w_lead) awvalid = 1'b1;
    end
    chk("wr_handshake_timeout", 128'(n >= 60), 0);
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b_timeout", 128'(n >= 40), 0);
    r = bresp;
    @(negedge clk);
    chk("bvalid_single_beat", 128'(bvalid), 0);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [31:0] d, output logic [1:0] r);
    int n = 0;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    while (!arready && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    arvalid = 1'b0;
    while (!rvalid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rd_timeout", 128'(n >= 40), 0);
    d = rdata; r = rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic pulse(input int c, input logic [31:0] d);
    @(negedge clk);
    res_data[c*32 +: 32] = d;
    res_valid[c] = 1'b1;
    @(negedge clk);
    res_valid = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [AW-1:0] addr, input logic [31:0] exp_d,
                        input logic [1:0] exp_r);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(addr, d, r);
    chk(tag, {96'(r), d}, {96'(exp_r), exp_d});
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    wdata = '0; wstrb = '0; res_data = '0; res_valid = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ready", {awready, wready, arready}, 3'b000);
    chk("rst_valid", {bvalid, rvalid}, 2'b00);
    chk("rst_resp_data", {bresp, rresp, rdata}, 36'h0);
    chk("rst_ctrl_out", ctrl_out, 128'h0);
`ifdef RESULT_SLV_IRQ_EN
    chk("rst_irq", 128'(irq), 0);
`endif
    rst = 1'b0;

    // Basic control write/readback
    for (int i = 0; i < 4; i++) begin
      axi_write(AW'(i * 4), 32'(i + 1), 4'hF, 0, resp);
      chk("ctrl_wr_bresp", 128'(resp), 0);
    end
    for (int i = 0; i < 4; i++) rd_chk("ctrl_readback", AW'(i * 4), 32'(i + 1), 2'b00);
    chk("ctrl_out_after_wr", ctrl_out, 128'h00000004_00000003_00000002_00000001);

    // W leads AW by 3 cycles with partial strobes
    axi_write(7'h00, 32'hFFFF_FFFF, 4'hF, 0, resp);
    axi_write(7'h00, 32'hA5A5_A5A5, 4'b0011, 3, resp);
    chk("w_lead_bresp", 128'(resp), 0);
    rd_chk("w_lead_strb_low", 7'h00, 32'hFFFF_A5A5, 2'b00);
    axi_write(7'h04, 32'h1234_5678, 4'b1100, 0, resp);
    rd_chk("strb_high", 7'h04, 32'h1234_0002, 2'b00);

    // Result load, STATUS/OVERRUN and W1C
    pulse(1, 32'h0000_0123);
    pulse(1, 32'h0000_0123);
    rd_chk("res1_value", 7'h14, 32'h0000_0123, 2'b00);
    rd_chk("status_after_2", 7'h20, 32'h2, 2'b00);
    rd_chk("overrun_after_2", 7'h24, 32'h2, 2'b00);
    axi_write(7'h20, 32'h2, 4'hF, 0, resp);
    rd_chk("status_w1c", 7'h20, 32'h0, 2'b00);
    axi_write(7'h24, 32'h2, 4'h0, 0, resp);
    rd_chk("overrun_w1c_nostrb", 7'h24, 32'h2, 2'b00);
    axi_write(7'h24, 32'h2, 4'h1, 0, resp);
    rd_chk("overrun_w1c", 7'h24, 32'h0, 2'b00);

    // Read sampled in the same cycle as a load returns the old value, held until RREADY
    pulse(2, 32'hAAAA_0002);
    @(negedge clk);
    araddr = 7'h18; arvalid = 1'b1;
    res_data[64 +: 32] = 32'hBBBB_0002; res_valid = 4'b0100;
    @(negedge clk);
    arvalid = 1'b0; res_valid = '0;
    chk("same_cycle_read_pre", {rvalid, rdata}, {1'b1, 32'hAAAA_0002});
    @(negedge clk);
    chk("rdata_held", {rvalid, rdata}, {1'b1, 32'hAAAA_0002});
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    rd_chk("res2_new", 7'h18, 32'hBBBB_0002, 2'b00);
    axi_write(7'h20, 32'hF, 4'hF, 0, resp);
    axi_write(7'h24, 32'hF, 4'hF, 0, resp);

    // Hardware set wins against a same-cycle W1C
    pulse(0, 32'h0000_0055);
    fork
      axi_write(7'h20, 32'h1, 4'hF, 0, resp);
      begin
        int n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!(awvalid && awready) && n < 40);
        @(negedge clk);
        res_data[31:0] = 32'h0000_0066; res_valid = 4'b0001;
        @(negedge clk);
        res_valid = '0;
      end
    join
    rd_chk("status_set_wins", 7'h20, 32'h1, 2'b00);
    rd_chk("overrun_set", 7'h24, 32'h1, 2'b00);
    rd_chk("res0_value", 7'h10, 32'h0000_0066, 2'b00);

    // Out-of-range and result-register writes
    rd_chk("oor_read", 7'h3F, 32'h0, 2'b10);
    axi_write(7'h3F, 32'hFFFF_FFFF, 4'hF, 0, resp);
    chk("oor_bresp", 128'(resp), 2);
    chk("oor_no_change", ctrl_out, 128'h00000004_00000003_12340002_FFFFA5A5);
    axi_write(7'h14, 32'h0, 4'hF, 0, resp);
    chk("res_wr_bresp", 128'(resp), 0);
    rd_chk("res_wr_ignored", 7'h14, 32'h0000_0123, 2'b00);
    rd_chk("status_unchanged", 7'h20, 32'h1, 2'b00);

`ifdef RESULT_SLV_IRQ_EN
    axi_write(7'h20, 32'hF, 4'hF, 0, resp);
    axi_write(7'h28, 32'h1, 4'hF, 0, resp);
    chk("irq_mask_bresp", 128'(resp), 0);
    rd_chk("irq_mask_read", 7'h28, 32'h1, 2'b00);
    chk("irq_idle", 128'(irq), 0);
    pulse(0, 32'h0000_0077);
    chk("irq_latency", 128'(irq), 0);
    @(negedge clk);
    chk("irq_high", 128'(irq), 1);
    axi_write(7'h20, 32'h1, 4'hF, 0, resp);
    chk("irq_low_after_w1c", 128'(irq), 0);
`else
    rd_chk("irq_mask_absent_rd", 7'h28, 32'h0, 2'b10);
    axi_write(7'h28, 32'h1, 4'hF, 0, resp);
    chk("irq_mask_absent_wr", 128'(resp), 2);
`endif

    // Reset while a W beat is held: transaction abandoned, bank cleared
    pulse(3, 32'h0000_0099);
    @(negedge clk);
    awaddr = 7'h00; wdata = 32'h0BAD_0BAD; wstrb = 4'hF; wvalid = 1'b1;
    begin
      int n = 0;
      while (!wready && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("hold_w_timeout", 128'(n >= 40), 0);
    end
    @(negedge clk);
    wvalid = 1'b0;
    rst = 1'b1;
    bready = 1'b1;
    bcount = 0;
    repeat (2) begin
      @(negedge clk);
      if (bvalid) bcount++;
    end
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bvalid) bcount++;
    end
    bready = 1'b0;
    chk("rst_mid_no_bvalid", 128'(bcount), 0);
    chk("rst_mid_ctrl_out", ctrl_out, 128'h0);
    rd_chk("rst_mid_ctrl0", 7'h00, 32'h0, 2'b00);
    rd_chk("rst_mid_res1", 7'h14, 32'h0, 2'b00);
    rd_chk("rst_mid_status", 7'h20, 32'h0, 2'b00);
    rd_chk("rst_mid_overrun", 7'h24, 32'h0, 2'b00);
`ifdef RESULT_SLV_IRQ_EN
    rd_chk("rst_mid_irq_mask", 7'h28, 32'h0, 2'b00);
    chk("rst_mid_irq", 128'(irq), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
